fifo_uart_tx: RTL and testbench

Downstream drain stage for the sync FIFO. It pops bytes from the FIFO read port and serializes each one as an asynchronous serial frame (start bit, 8 data bits LSB-first, stop bit) on a single line. It honours the FIFO's registered read data, which arrives one cycle after rd_en, and never issues a read while a frame is in flight. It sits between the FIFO and the chip-level serial pin.

---
 rtl/fifo_uart_tx_if.sv | 13 +
 rtl/fifo_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-port bundle between a sync FIFO and its drain stage.
//   fifo_empty  FIFO empty flag
//   fifo_data   registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  single-cycle read strobe from the drain stage
// master = the reader (fifo_uart_tx), slave = the FIFO.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;

    modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a sync FIFO and sends each one as a serial
// frame (start bit, 8 data bits LSB first, optional even parity, stop bit).
// Optional feature macro: FIFO_TX_PARITY_EN adds an even-parity bit after
// the data bits (11-bit frame instead of 10).
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   tx_en      permits starting new frames; a started frame always completes
//   fifo       FIFO read port (fifo_uart_tx_if.master)
//   tx         serial line, registered, idles high
//   busy       high whenever the FSM is not in IDLE
//   frame_cnt  completed-frame count, wraps
//
// state  | meaning
// IDLE   | line high, waiting for tx_en && !fifo_empty
// READ   | fifo_rd_en pulse
// WAIT   | FIFO read data valid; captured on exit
// START  | start bit (tx = 0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the byte (FIFO_TX_PARITY_EN only)
// STOP   | stop bit (tx = 1); frame_cnt bumps on exit
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    fifo_uart_tx_if.master       fifo,
    output logic                 tx,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_cnt
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_TX_PARITY_EN
        PARITY = 3'd6,
`endif
        STOP   = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [7:0]           shift_q, shift_n;
    logic [2:0]           bit_q, bit_n;
    logic [BAUD_W-1:0]    baud_q, baud_n;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic                 tx_n;
    logic                 rd_n;
    logic                 baud_done;
`ifdef FIFO_TX_PARITY_EN
    logic                 parity_q, parity_n;
`endif

    assign baud_done = (baud_q == BAUD_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            shift_q         <= '0;
            bit_q           <= '0;
            baud_q          <= '0;
            frame_cnt       <= '0;
            tx              <= 1'b1;
            fifo.fifo_rd_en <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            parity_q        <= 1'b0;
`endif
        end else begin
            state           <= state_n;
            shift_q         <= shift_n;
            bit_q           <= bit_n;
            baud_q          <= baud_n;
            frame_cnt       <= cnt_n;
            tx              <= tx_n;
            fifo.fifo_rd_en <= rd_n;
`ifdef FIFO_TX_PARITY_EN
            parity_q        <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        shift_n  = shift_q;
        bit_n    = bit_q;
        baud_n   = baud_q;
        cnt_n    = frame_cnt;
`ifdef FIFO_TX_PARITY_EN
        parity_n = parity_q;
`endif
        case (state)
            IDLE: begin
                if (tx_en && !fifo.fifo_empty) state_n = READ;
            end
            READ: state_n = WAIT;
            WAIT: begin
                shift_n  = fifo.fifo_data;
                baud_n   = '0;
`ifdef FIFO_TX_PARITY_EN
                parity_n = ^fifo.fifo_data;
`endif
                state_n  = START;
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef FIFO_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_n  = '0;
                    cnt_n   = frame_cnt + 1'b1;
                    state_n = IDLE;
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // tx and the read strobe are registered from the next state so they
        // change on the edge that enters each state or bit.
        rd_n = (state_n == READ);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;
    localparam int C  = 4;
    localparam int CW = 3;
`ifdef FIFO_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          tx_en = 1'b0;
    logic          tx;
    logic          busy;
    logic [CW-1:0] frame_cnt;

    int n_checks   = 0;
    int n_fail     = 0;
    int exp_frames = 0;
    int rd_cycles  = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    fifo_uart_tx_if fif ();

    fifo_uart_tx #(.CLKS_PER_BIT(C), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_en     (tx_en),
        .fifo      (fif),
        .tx        (tx),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model with registered read data
    assign fif.fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fif.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fif.fifo_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
        end
    end

    always @(negedge clk) if (fif.fifo_rd_en === 1'b1) rd_cycles++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    // Waits for a start bit, then checks the whole frame waveform of byte d.
    // gap = high samples seen before the start bit; lat = cycles from rd_en to start.
    task automatic recv_frame(input logic [7:0] d, input bit drop_en,
                              output int gap, output int lat);
        logic [10:0] bits;
        int rd_at, i, bad, bad_k;
        bit found;
        logic bad_got, bad_exp;
`ifdef FIFO_TX_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
`else
        bits = {2'b11, d, 1'b0};
`endif
        gap = 0; lat = -1; rd_at = -1; found = 0; i = 0;
        bad = 0; bad_k = 0; bad_got = 1'b0; bad_exp = 1'b0;
        while (!found && i < 400) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1;
            end else begin
                gap++;
                if (fif.fifo_rd_en === 1'b1) rd_at = i;
                i++;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL frame_start %02h: got no start bit, expected one within 400 cycles", d);
            return;
        end
        if (rd_at >= 0) lat = i - rd_at;
        if (drop_en) tx_en = 1'b0;
        for (int k = 0; k < NB * C; k++) begin
            if (k > 0) @(negedge clk);
            if (tx !== bits[k / C]) begin
                if (bad == 0) begin
                    bad_k = k; bad_got = tx; bad_exp = bits[k / C];
                end
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL frame_bits %02h: %0d bad samples, first at cycle %0d got %b expected %b",
                     d, bad, bad_k, bad_got, bad_exp);
        end
        exp_frames++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (fif.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fif.fifo_rd_en); end
        n_checks++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        reset = 1'b0;
        exp_frames = 0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int rd0, gap, lat;
        logic [CW-1:0] ef;
        rd0 = rd_cycles;
        push(8'hA5);
        tx_en = 1'b1;
        recv_frame(8'hA5, 1'b0, gap, lat);
        @(negedge clk); #1;
        ef = exp_frames[CW-1:0];
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
        n_checks++; if (rd_cycles - rd0 != 1) begin n_fail++; $display("FAIL single_rd_cycles: got %0d expected 1", rd_cycles - rd0); end
        n_checks++; if (frame_cnt !== ef) begin n_fail++; $display("FAIL single_frame_cnt: got %0d expected %0d", frame_cnt, ef); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
    endtask

    task automatic test_empty;
        int rd_hi, tx_lo, busy_hi;
        rd_hi = 0; tx_lo = 0; busy_hi = 0;
        tx_en = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (fif.fifo_rd_en !== 1'b0) rd_hi++;
            if (tx !== 1'b1) tx_lo++;
            if (busy !== 1'b0) busy_hi++;
        end
        n_checks++; if (rd_hi != 0) begin n_fail++; $display("FAIL empty_rd_en: got %0d strobes expected 0", rd_hi); end
        n_checks++; if (tx_lo != 0) begin n_fail++; $display("FAIL empty_tx: got %0d low cycles expected 0", tx_lo); end
        n_checks++; if (busy_hi != 0) begin n_fail++; $display("FAIL empty_busy: got %0d busy cycles expected 0", busy_hi); end
    endtask

    task automatic test_back_to_back;
        int rd0, gap, lat;
        logic [CW-1:0] ef;
        rd0 = rd_cycles;
        push(8'h00);
        push(8'hFF);
        recv_frame(8'h00, 1'b0, gap, lat);
        recv_frame(8'hFF, 1'b0, gap, lat);
        n_checks++; if (gap != 3) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 3", gap); end
        @(negedge clk); #1;
        ef = exp_frames[CW-1:0];
        n_checks++; if (rd_cycles - rd0 != 2) begin n_fail++; $display("FAIL b2b_rd_cycles: got %0d expected 2", rd_cycles - rd0); end
        n_checks++; if (frame_cnt !== ef) begin n_fail++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, ef); end
    endtask

    task automatic test_reset_mid;
        int i, gap, lat;
        bit found;
        logic [CW-1:0] ef;
        push(8'h3C);
        push(8'h5A);
        found = 0; i = 0;
        while (!found && i < 100) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
            i++;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rstmid_start: got no start bit, expected one within 100 cycles"); end
        repeat (C + 3 * C + 1) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL rstmid_frame_cnt: got %0d expected 0", frame_cnt); end
        exp_frames = 0;
        #3 reset = 1'b0;
        recv_frame(8'h5A, 1'b0, gap, lat);
        @(negedge clk); #1;
        ef = exp_frames[CW-1:0];
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 2", lat); end
        n_checks++; if (frame_cnt !== ef) begin n_fail++; $display("FAIL rstmid_after_cnt: got %0d expected %0d", frame_cnt, ef); end
    endtask

    task automatic test_tx_en_drop;
        int rd0, gap, lat;
        logic [CW-1:0] ef;
        rd0 = rd_cycles;
        push(8'h55);
        push(8'h66);
        recv_frame(8'h55, 1'b1, gap, lat);
        repeat (30) @(negedge clk);
        #1;
        n_checks++; if (rd_cycles - rd0 != 1) begin n_fail++; $display("FAIL drop_rd_cycles: got %0d expected 1", rd_cycles - rd0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b expected 0", busy); end
        ef = exp_frames[CW-1:0];
        n_checks++; if (frame_cnt !== ef) begin n_fail++; $display("FAIL drop_frame_cnt: got %0d expected %0d", frame_cnt, ef); end
        tx_en = 1'b1;
        recv_frame(8'h66, 1'b0, gap, lat);
        @(negedge clk); #1;
        ef = exp_frames[CW-1:0];
        n_checks++; if (frame_cnt !== ef) begin n_fail++; $display("FAIL drop_resume_cnt: got %0d expected %0d", frame_cnt, ef); end
    endtask

    task automatic test_random;
        logic [7:0] bytes [6];
        int gap, lat;
        logic [CW-1:0] ef;
        bytes[0] = 8'h07;
        for (int j = 1; j < 6; j++) bytes[j] = 8'($urandom_range(0, 255));
        for (int j = 0; j < 6; j++) push(bytes[j]);
        for (int j = 0; j < 6; j++) begin
            recv_frame(bytes[j], 1'b0, gap, lat);
            if (j > 0) begin
                n_checks++;
                if (gap != 3) begin n_fail++; $display("FAIL rand_gap %0d: got %0d expected 3", j, gap); end
            end
        end
        @(negedge clk); #1;
        ef = exp_frames[CW-1:0];
        n_checks++; if (frame_cnt !== ef) begin n_fail++; $display("FAIL rand_frame_cnt_wrap: got %0d expected %0d", frame_cnt, ef); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        test_tx_en_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
